// File: rtl/serial_parity_checker.sv
// Serial frame parity checker: DATA_BITS data bits then one parity bit, flagged against even/odd parity.
// Results register one cycle after the parity bit; start always restarts a frame (aborting any in flight).
module serial_parity_checker #(
  parameter int DATA_BITS = 8,
  parameter int ODD       = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       busy,
  output logic [7:0] bit_cnt,
  output logic       parity_out,
  output logic       parity_err,
  output logic       frame_done,
  output logic       aborted,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  localparam logic [7:0] LAST_BIT = 8'(DATA_BITS);
  localparam logic       ODD_BIT  = 1'(ODD);

  state_t     state, state_nxt;
  logic       acc, acc_nxt;
  logic [7:0] bit_cnt_nxt;
  logic       parity_out_nxt, parity_err_nxt;
  logic       frame_done_nxt, aborted_nxt;
  logic [7:0] err_cnt_nxt;
  logic       exp_par;
  logic       mismatch;

  assign exp_par  = acc ^ ODD_BIT;
  assign mismatch = bit_in ^ exp_par;

  always_comb begin
    state_nxt      = state;
    acc_nxt        = acc;
    bit_cnt_nxt    = bit_cnt;
    parity_out_nxt = parity_out;
    parity_err_nxt = parity_err;
    err_cnt_nxt    = err_cnt;
    frame_done_nxt = 1'b0;
    aborted_nxt    = 1'b0;

    // start outranks bit_valid everywhere, including the parity cycle
    if (start) begin
      aborted_nxt = (state != IDLE);
      state_nxt   = DATA;
      acc_nxt     = 1'b0;
      bit_cnt_nxt = 8'd0;
    end else if (bit_valid) begin
      case (state)
        DATA: begin
          acc_nxt     = acc ^ bit_in;
          bit_cnt_nxt = bit_cnt + 8'd1;
          if (bit_cnt + 8'd1 == LAST_BIT) state_nxt = PARITY;
        end
        PARITY: begin
          parity_out_nxt = exp_par;
          parity_err_nxt = mismatch;
          frame_done_nxt = 1'b1;
          state_nxt      = IDLE;
          if (mismatch && err_cnt != 8'hFF) err_cnt_nxt = err_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= 1'b0;
      bit_cnt    <= 8'd0;
      parity_out <= 1'b0;
      parity_err <= 1'b0;
      frame_done <= 1'b0;
      aborted    <= 1'b0;
      err_cnt    <= 8'd0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      bit_cnt    <= bit_cnt_nxt;
      parity_out <= parity_out_nxt;
      parity_err <= parity_err_nxt;
      frame_done <= frame_done_nxt;
      aborted    <= aborted_nxt;
      err_cnt    <= err_cnt_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_parity_checker.sv
// Scoreboard bench for serial_parity_checker: even-parity DUT checked via queue, odd-parity twin spot-checked.
module tb_serial_parity_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;

  logic       busy, parity_out, parity_err, frame_done, aborted;
  logic [7:0] bit_cnt, err_cnt;
  logic       o_busy, o_parity_out, o_parity_err, o_frame_done, o_aborted;
  logic [7:0] o_bit_cnt, o_err_cnt;

  serial_parity_checker #(.DATA_BITS(8), .ODD(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .busy(busy), .bit_cnt(bit_cnt), .parity_out(parity_out), .parity_err(parity_err),
    .frame_done(frame_done), .aborted(aborted), .err_cnt(err_cnt)
  );

  serial_parity_checker #(.DATA_BITS(8), .ODD(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .busy(o_busy), .bit_cnt(o_bit_cnt), .parity_out(o_parity_out), .parity_err(o_parity_err),
    .frame_done(o_frame_done), .aborted(o_aborted), .err_cnt(o_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_abort;
    logic       po;
    logic       pe;
    logic [7:0] ec;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_err = 0;
  int   frame_bits[8] = '{1, 0, 1, 1, 0, 0, 1, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every frame_done/aborted pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (frame_done || aborted)) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", {30'd0, frame_done, aborted}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("pulse_kind", {30'd0, frame_done, aborted}, e.is_abort ? 32'd1 : 32'd2);
        if (!e.is_abort) begin
          check("parity_out", {31'd0, parity_out}, {31'd0, e.po});
          check("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
          check("err_cnt",    {24'd0, err_cnt},    {24'd0, e.ec});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse(input bit expect_abort);
    exp_t e;
    if (expect_abort) begin
      e.is_abort = 1'b1; e.po = 1'b0; e.pe = 1'b0; e.ec = 8'd0;
      q.push_back(e);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic send_data(input bit gaps, input bit chk_cnt);
    for (int i = 0; i < 8; i++) begin
      if (gaps) repeat ($urandom_range(5)) tick();
      send_bit(frame_bits[i][0]);
      if (chk_cnt) check("bit_cnt_step", {24'd0, bit_cnt}, i + 1);
    end
  endtask

  // Data has four ones: even-parity expectation is 0, so parity bit 1 is an error.
  task automatic send_parity(input logic pbit);
    exp_t e;
    if (pbit && exp_err < 255) exp_err++;
    e.is_abort = 1'b0; e.po = 1'b0; e.pe = pbit; e.ec = 8'(exp_err);
    q.push_back(e);
    send_bit(pbit);
  endtask

  task automatic full_frame(input logic pbit, input bit gaps);
    start_pulse(1'b0);
    send_data(gaps, gaps);
    send_parity(pbit);
  endtask

  initial begin
    #3;
    check("rst_busy",    {31'd0, busy},       0);
    check("rst_bit_cnt", {24'd0, bit_cnt},    0);
    check("rst_err_cnt", {24'd0, err_cnt},    0);
    check("rst_done",    {31'd0, frame_done}, 0);
    #10 rst_n = 1'b1;
    tick();

    // Bits without start are ignored.
    send_bit(1'b1);
    check("idle_ignore_busy", {31'd0, busy},    0);
    check("idle_ignore_cnt",  {24'd0, bit_cnt}, 0);

    // Good frame, then busy drops after completion.
    full_frame(1'b0, 1'b0);
    check("good_busy_after", {31'd0, busy}, 0);
    check("odd_good_err",    {31'd0, o_parity_err}, 1);

    // Bad frame; the odd-parity twin sees this same frame as good.
    full_frame(1'b1, 1'b0);
    check("odd_parity_out", {31'd0, o_parity_out}, 1);
    check("odd_parity_err", {31'd0, o_parity_err}, 0);

    // Gapped frame with bit_cnt stepping.
    full_frame(1'b0, 1'b1);
    tick();
    check("gap_hold_err", {31'd0, parity_err}, 0);

    // Abort after 3 bits, then a good frame in the restarted DATA state.
    start_pulse(1'b0);
    for (int i = 0; i < 3; i++) send_bit(frame_bits[i][0]);
    check("pre_abort_cnt", {24'd0, bit_cnt}, 3);
    start_pulse(1'b1);
    check("abort_cnt",  {24'd0, bit_cnt}, 0);
    check("abort_busy", {31'd0, busy},    1);
    send_data(1'b0, 1'b1);
    send_parity(1'b0);

    // start coincident with the parity bit: abort wins, results hold.
    full_frame(1'b1, 1'b0);
    start_pulse(1'b0);
    send_data(1'b0, 1'b0);
    bit_in = 1'b0; bit_valid = 1'b1;
    start_pulse(1'b1);
    bit_valid = 1'b0;
    check("coinc_busy",   {31'd0, busy},       1);
    check("coinc_cnt",    {24'd0, bit_cnt},    0);
    check("coinc_hold_pe",{31'd0, parity_err}, 1);
    check("coinc_hold_ec",{24'd0, err_cnt},    exp_err);
    send_data(1'b0, 1'b0);
    send_parity(1'b0);

    // Asynchronous reset mid-frame, well away from the clock edge.
    full_frame(1'b1, 1'b0);
    start_pulse(1'b0);
    for (int i = 0; i < 3; i++) send_bit(frame_bits[i][0]);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",    {31'd0, busy},         0);
    check("arst_cnt",     {24'd0, bit_cnt},      0);
    check("arst_pe",      {31'd0, parity_err},   0);
    check("arst_ec",      {24'd0, err_cnt},      0);
    check("arst_odd_po",  {31'd0, o_parity_out}, 0);
    check("arst_aborted", {31'd0, aborted},      0);
    exp_err = 0;
    tick();
    rst_n = 1'b1;
    tick();
    send_data(1'b0, 1'b0);
    send_bit(1'b1);
    check("post_rst_busy", {31'd0, busy},    0);
    check("post_rst_cnt",  {24'd0, bit_cnt}, 0);

    // Saturation.
    for (int f = 0; f < 260; f++) full_frame(1'b1, 1'b0);
    repeat (5) tick();
    check("sat_err_cnt", {24'd0, err_cnt}, 255);
    full_frame(1'b1, 1'b0);
    tick();
    check("sat_hold", {24'd0, err_cnt}, 255);

    for (int i = 0; i < 20 && q.size() != 0; i++) tick();
    check("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_parity_checker.md
SERIAL_PARITY_CHECKER -- requirements
Module: serial_parity_checker

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, giving data bits per frame; legal range 2..255.
REQ-002 The block SHALL have parameter ODD, default 0, selecting parity sense: 0 = even, 1 = odd.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port start, input, 1 bit: start-of-frame strobe.
REQ-006 Port bit_in, input, 1 bit: serial data or parity bit.
REQ-007 Port bit_valid, input, 1 bit: bit_in is sampled this cycle.
REQ-008 Port busy, output, 1 bit: high while a frame is in progress.
REQ-009 Port bit_cnt, output, 8 bits: data bits accepted in the current frame.
REQ-010 Port parity_out, output, 1 bit: expected parity of the last completed frame.
REQ-011 Port parity_err, output, 1 bit: received parity mismatched on the last completed frame.
REQ-012 Port frame_done, output, 1 bit: one-cycle pulse on frame completion.
REQ-013 Port aborted, output, 1 bit: one-cycle pulse when a frame in progress is discarded by start.
REQ-014 Port err_cnt, output, 8 bits: saturating count of parity errors.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, DATA and PARITY.
REQ-016 In IDLE, start=1 SHALL move the FSM to DATA, clear the accumulator and clear bit_cnt; bit_valid in that same cycle is ignored.
REQ-017 In IDLE without start, bit_valid SHALL be ignored.
REQ-018 In DATA, each bit_valid=1 cycle SHALL XOR bit_in into the accumulator and increment bit_cnt by 1.
REQ-019 When the accepted bit makes bit_cnt equal DATA_BITS, the FSM SHALL move to PARITY.
REQ-020 Cycles with bit_valid=0 SHALL leave all state unchanged; gaps of any length are legal.
REQ-021 In PARITY, bit_valid=1 SHALL register parity_out = accumulator XOR ODD and parity_err = (bit_in != parity_out).
REQ-022 In that same PARITY bit_valid=1 cycle, frame_done SHALL be asserted on the following cycle for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-023 A parity error SHALL increment err_cnt by 1, saturating at 255.
REQ-024 parity_out and parity_err SHALL hold their value until the next frame completes.
REQ-025 start=1 in DATA or PARITY SHALL abort the frame: pulse aborted for one cycle, restart the frame per REQ-016 and remain in/enter DATA.
REQ-026 An aborted frame SHALL NOT change parity_out, parity_err, err_cnt or frame_done.
REQ-027 start SHALL have priority over bit_valid in all states, including the PARITY completion cycle.
REQ-028 busy SHALL be 1 exactly when the state is DATA or PARITY.
REQ-029 Outputs SHALL be registered with no combinational path from inputs to outputs.

Reset
REQ-030 rst_n=0 SHALL immediately, regardless of clk, force: state IDLE; busy, bit_cnt, parity_out, parity_err, frame_done, aborted and err_cnt all 0; accumulator 0.
REQ-031 Reset asserted mid-frame SHALL discard the frame with no frame_done or aborted pulse.
REQ-032 After rst_n deasserts, the block SHALL need a start before accepting bits.

Verification (DATA_BITS=8, ODD=0)
REQ-033 Reset check: rst_n low mid-frame -> all outputs 0 asynchronously; bits sent afterwards without start -> ignored, busy=0.
REQ-034 Good frame: start, bits 1,0,1,1,0,0,1,0, parity bit 0 -> frame_done single pulse, parity_out=0, parity_err=0, err_cnt=0, busy=0 afterwards.
REQ-035 Bad frame with the same data and parity bit 1 -> parity_err=1, err_cnt=1. ODD=1 build with parity bit 1 -> parity_err=0.
REQ-036 Valid gaps: the REQ-034 frame with 0-5 idle cycles randomly between bits -> identical result and bit_cnt stepping 1..8.
REQ-037 Abort: start, 3 bits, start again -> aborted pulse, bit_cnt=0, no frame_done. A following full good frame -> correct result. start coincident with the parity bit -> abort, not completion.
REQ-038 Saturation: 260 bad frames -> err_cnt=255 and holding.
